// File: rtl/ex_mem_pipe_reg_if.sv
// Bus bundle for ex_mem_pipe_reg: input entry and advance/flush controls
// in, last-stage entry and observability counters out.
interface ex_mem_pipe_reg_if #(
    parameter int DATA_W = 51,
    parameter int CTRL_W = 6,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              hit;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output hit, flush, in_valid, in_ctrl, in_data,
        input  out_valid, out_ctrl, out_data, occupancy, stall_cnt
    );

    modport slave (
        input  hit, flush, in_valid, in_ctrl, in_data,
        output out_valid, out_ctrl, out_data, occupancy, stall_cnt
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// Parametrised pipeline boundary register: DEPTH stages of {valid, ctrl, data}
// with global stall, flush-to-bubble, saturating stall counter and occupancy.
module ex_mem_pipe_reg #(
    parameter int DATA_W = 51,
    parameter int CTRL_W = 6,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    ex_mem_pipe_reg_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  v_next;
    logic [CTRL_W-1:0] c [DEPTH];
    logic [DATA_W-1:0] d [DEPTH];
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_next;
    logic [CNT_W-1:0]  stall_q;

    // Next valid vector feeds both the v registers and the occupancy count,
    // so occupancy always matches the stages it describes.
    always_comb begin
        v_next   = v;
        occ_next = '0;
        if (rst || bus.flush) begin
            v_next = '0;
        end else if (bus.hit) begin
            v_next[0] = bus.in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                v_next[k] = v[k-1];
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            occ_next = occ_next + OCC_W'(v_next[k]);
        end
    end

    // NOTE: all state moves on the falling edge, and uses non-blocking
    // assignments so every stage samples its predecessor's old value.
    always_ff @(negedge clk) begin
        if (rst) begin
            v       <= '0;
            occ_q   <= '0;
            stall_q <= '0;
            // NOTE: the payload array is cleared too, so out_data reads 0 after reset.
            for (int k = 0; k < DEPTH; k++) begin
                c[k] <= '0;
                d[k] <= '0;
            end
        end else begin
            v     <= v_next;
            occ_q <= occ_next;
            if (bus.flush) begin
                // Bubbles keep their payload but must carry no control.
                for (int k = 0; k < DEPTH; k++) begin
                    c[k] <= '0;
                end
            end else if (bus.hit) begin
                c[0] <= bus.in_valid ? bus.in_ctrl : '0;
                d[0] <= bus.in_data;
                for (int k = 1; k < DEPTH; k++) begin
                    c[k] <= c[k-1];
                    d[k] <= d[k-1];
                end
            end else if (stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_ctrl  = c[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.occupancy = occ_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: table-driven DEPTH=2 run with a
// scoreboard, plus hand sequences for stall (DEPTH=1), flush and saturation.
module tb_ex_mem_pipe_reg;
    logic clk = 1'b0;
    logic rst1, rst2, rst3;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg_if #(.DEPTH(1))             if1 ();
    ex_mem_pipe_reg_if #(.DEPTH(2))             if2 ();
    ex_mem_pipe_reg_if #(.DEPTH(3), .CNT_W(2))  if3 ();

    ex_mem_pipe_reg #(.DEPTH(1))            u1 (.clk(clk), .rst(rst1), .bus(if1.slave));
    ex_mem_pipe_reg #(.DEPTH(2))            u2 (.clk(clk), .rst(rst2), .bus(if2.slave));
    ex_mem_pipe_reg #(.DEPTH(3), .CNT_W(2)) u3 (.clk(clk), .rst(rst3), .bus(if3.slave));

    typedef struct {
        logic        rst;
        logic        hit;
        logic        flush;
        logic        in_valid;
        logic [5:0]  in_ctrl;
        logic [63:0] in_data;
        logic        e_valid;
        logic [5:0]  e_ctrl;
        logic [63:0] e_data;
        int          e_occ;
        int          e_stall;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [5:0]  ctrl;
        logic [63:0] data;
        int          occ;
        int          stall;
    } exp_t;

    vec_t tbl [11];
    exp_t sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Sample just after the falling (active) edge; inputs are then driven
    // well before the next falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1);
    end

    initial begin
        exp_t e;

        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        {if1.hit, if1.flush, if1.in_valid, if1.in_ctrl, if1.in_data} = '0;
        {if2.hit, if2.flush, if2.in_valid, if2.in_ctrl, if2.in_data} = '0;
        {if3.hit, if3.flush, if3.in_valid, if3.in_ctrl, if3.in_data} = '0;

        // rst hit flush iv ctrl data | valid ctrl data occ stall  (DEPTH=2)
        tbl[0]  = '{1, 0, 0, 0, 6'h00, 64'h0,    0, 6'h00, 64'h0,    0, 0};
        tbl[1]  = '{0, 1, 0, 1, 6'h12, 64'h1,    0, 6'h00, 64'h0,    1, 0};
        tbl[2]  = '{0, 1, 0, 1, 6'h12, 64'h2,    1, 6'h12, 64'h1,    2, 0};
        tbl[3]  = '{0, 1, 0, 1, 6'h12, 64'h3,    1, 6'h12, 64'h2,    2, 0};
        tbl[4]  = '{0, 1, 0, 1, 6'h12, 64'h4,    1, 6'h12, 64'h3,    2, 0};
        tbl[5]  = '{0, 1, 0, 0, 6'h3F, 64'hAAAA, 1, 6'h12, 64'h4,    1, 0};
        tbl[6]  = '{0, 1, 0, 0, 6'h3F, 64'hAAAA, 0, 6'h00, 64'hAAAA, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 6'h21, 64'h5,    0, 6'h00, 64'hAAAA, 0, 1};
        tbl[8]  = '{0, 1, 0, 1, 6'h21, 64'h6,    0, 6'h00, 64'hAAAA, 1, 1};
        tbl[9]  = '{1, 1, 0, 1, 6'h21, 64'h7,    0, 6'h00, 64'h0,    0, 0};
        tbl[10] = '{0, 1, 0, 1, 6'h01, 64'h9,    0, 6'h00, 64'h0,    1, 0};

        for (int i = 0; i < 11; i++) begin
            rst2         = tbl[i].rst;
            if2.hit      = tbl[i].hit;
            if2.flush    = tbl[i].flush;
            if2.in_valid = tbl[i].in_valid;
            if2.in_ctrl  = tbl[i].in_ctrl;
            if2.in_data  = tbl[i].in_data[50:0];
            sb.push_back('{tbl[i].e_valid, tbl[i].e_ctrl, tbl[i].e_data, tbl[i].e_occ, tbl[i].e_stall});
            tick();
            e = sb.pop_front();
            check($sformatf("v%0d.out_valid", i), 64'(if2.out_valid), 64'(e.valid));
            check($sformatf("v%0d.out_ctrl", i),  64'(if2.out_ctrl),  64'(e.ctrl));
            check($sformatf("v%0d.out_data", i),  64'(if2.out_data),  e.data);
            check($sformatf("v%0d.occupancy", i), 64'(if2.occupancy), 64'(e.occ));
            check($sformatf("v%0d.stall_cnt", i), 64'(if2.stall_cnt), 64'(e.stall));
        end
        rst2 = 1'b1;

        // Stall hold, DEPTH=1
        tick();
        check("d1.reset_stall", 64'(if1.stall_cnt), 64'd0);
        check("d1.reset_valid", 64'(if1.out_valid), 64'd0);
        rst1 = 1'b0;
        if1.hit = 1'b1; if1.in_valid = 1'b1; if1.in_ctrl = 6'h12; if1.in_data = 51'hBEEF;
        tick();
        check("d1.load_data",  64'(if1.out_data),  64'hBEEF);
        check("d1.load_valid", 64'(if1.out_valid), 64'd1);
        check("d1.load_ctrl",  64'(if1.out_ctrl),  64'h12);
        check("d1.load_occ",   64'(if1.occupancy), 64'd1);
        if1.hit = 1'b0; if1.in_data = 51'h1234;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("d1.stall%0d_data", k), 64'(if1.out_data),  64'hBEEF);
            check($sformatf("d1.stall%0d_cnt", k),  64'(if1.stall_cnt), 64'(k));
        end
        if1.hit = 1'b1;
        tick();
        check("d1.resume_data", 64'(if1.out_data),  64'h1234);
        check("d1.resume_cnt",  64'(if1.stall_cnt), 64'd3);
        if1.hit = 1'b0; if1.flush = 1'b1;
        tick();
        check("d1.flush_valid", 64'(if1.out_valid), 64'd0);
        check("d1.flush_ctrl",  64'(if1.out_ctrl),  64'd0);
        check("d1.flush_data",  64'(if1.out_data),  64'h1234);
        check("d1.flush_cnt",   64'(if1.stall_cnt), 64'd3);
        check("d1.flush_occ",   64'(if1.occupancy), 64'd0);
        if1.flush = 1'b0;

        // Flush priority, DEPTH=3
        rst3 = 1'b0;
        if3.hit = 1'b1; if3.in_valid = 1'b1; if3.in_ctrl = 6'h0A;
        for (int k = 0; k < 3; k++) begin
            if3.in_data = 51'(16 + k);
            tick();
        end
        check("d3.full_data",  64'(if3.out_data),  64'h10);
        check("d3.full_valid", 64'(if3.out_valid), 64'd1);
        check("d3.full_occ",   64'(if3.occupancy), 64'd3);
        if3.hit = 1'b0;
        tick();
        check("d3.stall_cnt", 64'(if3.stall_cnt), 64'd1);
        if3.hit = 1'b1; if3.flush = 1'b1; if3.in_data = 51'h99;
        tick();
        check("d3.flush_valid", 64'(if3.out_valid), 64'd0);
        check("d3.flush_ctrl",  64'(if3.out_ctrl),  64'd0);
        check("d3.flush_data",  64'(if3.out_data),  64'h10);
        check("d3.flush_occ",   64'(if3.occupancy), 64'd0);
        check("d3.flush_cnt",   64'(if3.stall_cnt), 64'd1);
        if3.flush = 1'b0; if3.in_data = 51'h20;
        tick();
        check("d3.refill_occ", 64'(if3.occupancy), 64'd1);
        if3.in_valid = 1'b0;
        tick();
        tick();
        check("d3.refill_data",  64'(if3.out_data),  64'h20);
        check("d3.refill_valid", 64'(if3.out_valid), 64'd1);
        check("d3.refill_ctrl",  64'(if3.out_ctrl),  64'h0A);

        // Saturation, CNT_W=2
        rst3 = 1'b1;
        tick();
        check("sat.reset", 64'(if3.stall_cnt), 64'd0);
        rst3 = 1'b0; if3.hit = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("sat.edge%0d", k), 64'(if3.stall_cnt), 64'((k > 3) ? 3 : k));
        end
        rst3 = 1'b1;
        tick();
        check("sat.clear", 64'(if3.stall_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised pipeline boundary register. It is the generalised successor of the fixed execute/memory latch and sits between any two pipeline stages of the 16-bit processor. It carries a data payload and a control field through `DEPTH` register stages. Beyond the plain latch it adds a valid bit per stage, a global advance/stall input, a flush that turns in-flight entries into bubbles, synchronous reset, and stall/occupancy observability.

## Interface
- `DATA_W`, default 51: payload width. Default covers ALU result, adder result, read data 2 (16 bits each) plus 3-bit destination register.
- `CTRL_W`, default 6: control field width. Default covers MemToReg, RegWrite, MemRead, MemWrite, Branch and Zero. The control field is forced to 0 in every bubble.
- `DEPTH`, default 1: number of register stages. Legal range 1..8.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk`  in  1: clock. All state updates on the falling edge.
- `rst`  in  1: synchronous reset, active-high, sampled on the falling edge.
- `hit`  in  1: advance enable. 1 = shift, 0 = global stall (hold).
- `flush`  in  1: kill all in-flight entries.
- `in_valid`  in  1: input entry is a real instruction.
- `in_ctrl`  in  CTRL_W: control field of the input entry.
- `in_data`  in  DATA_W: payload of the input entry.
- `out_valid`  out  1: last stage valid.
- `out_ctrl`  out  CTRL_W: last stage control.
- `out_data`  out  DATA_W: last stage payload.
- `occupancy`  out  clog2(DEPTH+1): number of valid stages.
- `stall_cnt`  out  CNT_W: saturating count of stall cycles.

## Operation
- Each stage k (0..DEPTH-1) holds `v[k]`, `c[k]`, `d[k]`. Stage 0 is the input side; outputs are driven directly from stage DEPTH-1 registers, with no combinational path from inputs.
- Invariant: `v[k]=0` implies `c[k]=0` at all times.
- Priority at each falling edge: rst > flush > hit.
- rst=1:
  - all `v`=0, `c`=0, `d`=0.
  - `stall_cnt`=0, `occupancy`=0.
- flush=1 (rst=0):
  - all `v`=0, `c`=0; `d` holds.
  - The input entry is discarded regardless of `hit`.
  - `stall_cnt` unchanged.
- hit=1 (rst=0, flush=0):
  - `v[0]`<=`in_valid`.
  - `c[0]`<=`in_valid ? in_ctrl : 0`.
  - `d[0]`<=`in_data`. The payload is always captured.
  - Stage k<=stage k-1 for k≥1.
- hit=0 (rst=0, flush=0):
  - all stages hold.
  - `stall_cnt` increments by 1, saturating at 2^CNT_W-1, and never wraps.
- `occupancy` is a register updated on the same edge to the population count of the next `v` vector. It never exceeds DEPTH.
- `stall_cnt` clears only on rst.

## Timing
- Latency: an entry presented with hit=1 at edge N appears on the outputs after edge N+DEPTH-1. Each additional stall edge adds one cycle.
- Throughput: one entry per advancing edge; no bubbles are inserted except via `in_valid`=0 or `flush`.
- Reset values: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `stall_cnt`=0. These are valid from the first falling edge with rst=1; before that edge the outputs are undefined.
- Reset mid-stream clears everything on that edge; in-flight entries are lost.
- flush and hit both 1: flush wins; nothing shifts in.
- flush with hit=0: stages still clear, and the stall is not counted on that edge.
- `in_valid`=1 with hit=0: the entry is not captured. The upstream stage must hold it.
- Saturation: at `stall_cnt`=2^CNT_W-1 further stall edges leave it unchanged.

## Test plan
- Reset: DEPTH=2, rst=1 for one edge with arbitrary prior state -> `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `stall_cnt`=0.
- Streaming: DEPTH=2, hit=1, present `in_data`=0x0001…0x0004 with `in_ctrl`=6'h12 and `in_valid`=1 on consecutive edges -> `out_data`=0x0001 after the 2nd edge, then 0x0002, 0x0003, 0x0004 on the following edges; `occupancy`=1, then 2, then stays 2.
- Stall: DEPTH=1, hit=1 loads 0xBEEF, then hit=0 for 3 edges while `in_data`=0x1234 -> `out_data` stays 0xBEEF; `stall_cnt`=3; the next hit=1 edge loads 0x1234.
- Bubble: `in_valid`=0 with `in_ctrl`=6'h3F and `in_data`=0xAAAA, hit=1 -> `out_valid`=0, `out_ctrl`=0, `out_data`=0xAAAA.
- Flush priority: DEPTH=3 full, flush=1 and hit=1 with `in_valid`=1 -> all valid bits 0, `occupancy`=0, `out_ctrl`=0, `stall_cnt` unchanged.
- Saturation: CNT_W=2, hit=0 for 5 edges -> `stall_cnt` reads 1,2,3,3,3; rst=1 -> 0.
